// File: rtl/ddr_app_arbiter_nch.sv
// N-channel arbiter onto one DDR app port; read data is routed back via an in-order tag FIFO.
// Optional per-channel perf counters are enabled by defining DDR_ARB_PERF_EN.
module ddr_app_arbiter_nch #(
   parameter int unsigned NUM_CH    = 2,
   parameter int unsigned ADDR_W    = 28,
   parameter int unsigned DATA_W    = 512,
   parameter int unsigned TAG_DEPTH = 16,
   parameter int unsigned ARB_MODE  = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_CH-1:0]            ch_en,
   input  logic [3*NUM_CH-1:0]          ch_cmd,
   input  logic [ADDR_W*NUM_CH-1:0]     ch_addr,
   input  logic [DATA_W*NUM_CH-1:0]     ch_wdf_data,
   input  logic [(DATA_W/8)*NUM_CH-1:0] ch_wdf_mask,
   output logic [NUM_CH-1:0]            ch_rdy,
   output logic [DATA_W-1:0]            ch_rd_data,
   output logic [NUM_CH-1:0]            ch_rd_valid,
   output logic [ADDR_W-1:0]            app_addr,
   output logic [2:0]                   app_cmd,
   output logic                         app_en,
   output logic [DATA_W-1:0]            app_wdf_data,
   output logic [DATA_W/8-1:0]          app_wdf_mask,
   output logic                         app_wdf_wren,
   output logic                         app_wdf_end,
   input  logic                         app_rdy,
   input  logic                         app_wdf_rdy,
   input  logic [DATA_W-1:0]            app_rd_data,
   input  logic                         app_rd_data_valid,
`ifdef DDR_ARB_PERF_EN
   input  logic                         perf_clr,
   output logic [32*NUM_CH-1:0]         perf_cnt,
   output logic [32*NUM_CH-1:0]         perf_stall,
`endif
   output logic                         tag_err
);

   localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned MW   = DATA_W / 8;
   localparam int unsigned AW   = $clog2(TAG_DEPTH);
   localparam logic [AW:0] FULL_OCC = (AW+1)'(TAG_DEPTH);

   typedef enum logic {IDLE, OWN} state_t;

   state_t            state_q;
   logic [CH_W-1:0]   owner_q, rr_q;
   logic [CH_W-1:0]   tag_mem [TAG_DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [AW:0]       occ_q, occ_d;
   logic              tag_err_q, tag_err_d;

   logic [CH_W-1:0]   win, sel, cand;
   logic              win_vld, sel_vld;
   int unsigned       idx;
   logic [2:0]        cmd;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [MW-1:0]     wmask;
   logic              is_wr, is_rd, pop, push, fifo_ok, accept;

   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      idx     = 0;
      cand    = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         idx  = (ARB_MODE == 0) ? (32'(rr_q) + i) % NUM_CH : i;
         cand = CH_W'(idx);
         if (!win_vld && ch_en[cand]) begin
            win_vld = 1'b1;
            win     = cand;
         end
      end
   end

   // OWN locks the mux to the owner; outputs are forced quiet while reset is asserted.
   always_comb begin
      sel     = (state_q == OWN) ? owner_q : win;
      sel_vld = rst_n && ((state_q == OWN) ? ch_en[owner_q] : win_vld);
      cmd     = '0;
      addr    = '0;
      wdata   = '0;
      wmask   = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (sel_vld && sel == CH_W'(i)) begin
            cmd   = ch_cmd[3*i +: 3];
            addr  = ch_addr[ADDR_W*i +: ADDR_W];
            wdata = ch_wdf_data[DATA_W*i +: DATA_W];
            wmask = ch_wdf_mask[MW*i +: MW];
         end
      end
      is_wr   = (cmd == 3'b000);
      is_rd   = (cmd == 3'b001);
      pop     = rst_n && app_rd_data_valid && (occ_q != '0);
      fifo_ok = (occ_q != FULL_OCC) || pop;
      app_en  = sel_vld && (!is_rd || fifo_ok);
      accept  = app_en && app_rdy && (!is_wr || app_wdf_rdy);
      push    = accept && is_rd;

      app_addr     = addr;
      app_cmd      = cmd;
      app_wdf_data = wdata;
      app_wdf_mask = wmask;
      app_wdf_wren = app_en && is_wr;
      app_wdf_end  = app_en && is_wr;
      ch_rd_data   = rst_n ? app_rd_data : '0;
      ch_rdy       = '0;
      ch_rd_valid  = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         ch_rdy[i]      = accept && (sel == CH_W'(i));
         ch_rd_valid[i] = pop && (tag_mem[rd_ptr_q] == CH_W'(i));
      end

      occ_d = occ_q;
      case ({push, pop})
         2'b10:   occ_d = occ_q + (AW+1)'(1);
         2'b01:   occ_d = occ_q - (AW+1)'(1);
         default: occ_d = occ_q;
      endcase
      tag_err_d = tag_err_q || (app_rd_data_valid && (occ_q == '0));
   end

   assign tag_err = tag_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         owner_q   <= '0;
         rr_q      <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         occ_q     <= '0;
         tag_err_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (win_vld && !accept) begin
               state_q <= OWN;
               owner_q <= win;
            end
            OWN:  if (accept) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
         if (accept) rr_q <= (sel == CH_W'(NUM_CH-1)) ? '0 : sel + CH_W'(1);
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         occ_q     <= occ_d;
         tag_err_q <= tag_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) tag_mem[wr_ptr_q] <= sel;
   end

`ifdef DDR_ARB_PERF_EN
   logic [31:0] perf_cnt_q   [NUM_CH];
   logic [31:0] perf_stall_q [NUM_CH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            perf_cnt_q[i]   <= '0;
            perf_stall_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (perf_clr) begin
               perf_cnt_q[i]   <= '0;
               perf_stall_q[i] <= '0;
            end else begin
               if (ch_rdy[i] && perf_cnt_q[i] != '1)
                  perf_cnt_q[i] <= perf_cnt_q[i] + 32'd1;
               if (ch_en[i] && !ch_rdy[i] && perf_stall_q[i] != '1)
                  perf_stall_q[i] <= perf_stall_q[i] + 32'd1;
            end
         end
      end
   end

   always_comb begin
      perf_cnt   = '0;
      perf_stall = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         perf_cnt[32*i +: 32]   = perf_cnt_q[i];
         perf_stall[32*i +: 32] = perf_stall_q[i];
      end
   end
`endif

endmodule

// File: tb/tb_ddr_app_arbiter_nch.sv
// Directed bench: round-robin/tag-FIFO vector table plus reset and fixed-priority sequences.
module tb_ddr_app_arbiter_nch;
   localparam int NCH = 2;
   localparam int AW  = 28;
   localparam int DW  = 32;
   localparam int MW  = DW / 8;

   localparam logic [2:0] W = 3'b000;
   localparam logic [2:0] R = 3'b001;
   localparam logic [2:0] X = 3'b010;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [NCH-1:0] ch_en;
   logic [2:0]     c0, c1;
   logic [AW-1:0]  a0, a1;
   logic           app_rdy, app_wdf_rdy, app_rd_data_valid;
   logic [DW-1:0]  app_rd_data;
   logic           perf_clr;

   logic [3*NCH-1:0]  ch_cmd;
   logic [AW*NCH-1:0] ch_addr;
   logic [DW*NCH-1:0] ch_wdf_data;
   logic [MW*NCH-1:0] ch_wdf_mask;
   assign ch_cmd      = {c1, c0};
   assign ch_addr     = {a1, a0};
   assign ch_wdf_data = {4'hD, a1, 4'hD, a0};
   assign ch_wdf_mask = {a1[3:0], a0[3:0]};

   logic [NCH-1:0] rr_ch_rdy, rr_rd_valid, pr_ch_rdy, pr_rd_valid;
   logic [DW-1:0]  rr_rd_data, pr_rd_data, rr_wdata, pr_wdata;
   logic [AW-1:0]  rr_addr, pr_addr;
   logic [2:0]     rr_cmd, pr_cmd;
   logic           rr_en, pr_en, rr_wren, pr_wren, rr_wend, pr_wend, rr_err, pr_err;
   logic [MW-1:0]  rr_mask, pr_mask;
`ifdef DDR_ARB_PERF_EN
   logic [32*NCH-1:0] rr_pcnt, rr_pstall, pr_pcnt, pr_pstall;
`endif

   ddr_app_arbiter_nch #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .TAG_DEPTH(4), .ARB_MODE(0)) u_rr (
      .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .ch_cmd(ch_cmd), .ch_addr(ch_addr),
      .ch_wdf_data(ch_wdf_data), .ch_wdf_mask(ch_wdf_mask), .ch_rdy(rr_ch_rdy),
      .ch_rd_data(rr_rd_data), .ch_rd_valid(rr_rd_valid), .app_addr(rr_addr), .app_cmd(rr_cmd),
      .app_en(rr_en), .app_wdf_data(rr_wdata), .app_wdf_mask(rr_mask), .app_wdf_wren(rr_wren),
      .app_wdf_end(rr_wend), .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
      .app_rd_data_valid(app_rd_data_valid),
`ifdef DDR_ARB_PERF_EN
      .perf_clr(perf_clr), .perf_cnt(rr_pcnt), .perf_stall(rr_pstall),
`endif
      .tag_err(rr_err));

   ddr_app_arbiter_nch #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .TAG_DEPTH(16), .ARB_MODE(1)) u_pr (
      .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .ch_cmd(ch_cmd), .ch_addr(ch_addr),
      .ch_wdf_data(ch_wdf_data), .ch_wdf_mask(ch_wdf_mask), .ch_rdy(pr_ch_rdy),
      .ch_rd_data(pr_rd_data), .ch_rd_valid(pr_rd_valid), .app_addr(pr_addr), .app_cmd(pr_cmd),
      .app_en(pr_en), .app_wdf_data(pr_wdata), .app_wdf_mask(pr_mask), .app_wdf_wren(pr_wren),
      .app_wdf_end(pr_wend), .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
      .app_rd_data_valid(app_rd_data_valid),
`ifdef DDR_ARB_PERF_EN
      .perf_clr(perf_clr), .perf_cnt(pr_pcnt), .perf_stall(pr_pstall),
`endif
      .tag_err(pr_err));

   typedef struct {
      logic [1:0]    en;
      logic [2:0]    c0, c1;
      logic [AW-1:0] a0, a1;
      logic          rdy, wrdy, rdv;
      logic [1:0]    x_rdy;
      logic          x_en, x_wren;
      logic [AW-1:0] x_addr;
      logic [1:0]    x_rdv;
      logic          x_err;
   } vec_t;

   vec_t tv[$];
   int   n_chk = 0;
   int   n_err = 0;

   function automatic vec_t mk(logic [1:0] en, logic [2:0] cc0, logic [2:0] cc1,
                               logic [AW-1:0] aa0, logic [AW-1:0] aa1,
                               logic rdy, logic wrdy, logic rdv,
                               logic [1:0] xr, logic xe, logic xw, logic [AW-1:0] xa,
                               logic [1:0] xv, logic xerr);
      vec_t v;
      v.en = en; v.c0 = cc0; v.c1 = cc1; v.a0 = aa0; v.a1 = aa1;
      v.rdy = rdy; v.wrdy = wrdy; v.rdv = rdv;
      v.x_rdy = xr; v.x_en = xe; v.x_wren = xw; v.x_addr = xa; v.x_rdv = xv; v.x_err = xerr;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      ch_en = '0; c0 = W; c1 = W; a0 = '0; a1 = '0;
      app_rdy = 1'b0; app_wdf_rdy = 1'b0; app_rd_data_valid = 1'b0;
   endtask

   initial begin
      perf_clr = 1'b0;
      app_rd_data = '0;
      idle_inputs();
      rst_n = 1'b0;

      // outputs must be quiet during reset even with live requests
      ch_en = 2'b11; a0 = 28'h111; a1 = 28'h222; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
      app_rd_data_valid = 1'b1;
      #1;
      chk("rst ch_rdy", 64'(rr_ch_rdy), 64'h0);
      chk("rst app_en", 64'(rr_en), 64'h0);
      chk("rst wren", 64'(rr_wren), 64'h0);
      chk("rst addr", 64'(rr_addr), 64'h0);
      chk("rst rd_valid", 64'(rr_rd_valid), 64'h0);
      chk("rst tag_err", 64'(rr_err), 64'h0);
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;

      tv.push_back(mk(2'b11, W, W, 28'h10, 28'h20, 1, 1, 0, 2'b01, 1, 1, 28'h10, 2'b00, 0));
      tv.push_back(mk(2'b11, W, W, 28'h10, 28'h20, 1, 1, 0, 2'b10, 1, 1, 28'h20, 2'b00, 0));
      tv.push_back(mk(2'b11, W, W, 28'h10, 28'h20, 1, 1, 0, 2'b01, 1, 1, 28'h10, 2'b00, 0));
      tv.push_back(mk(2'b11, W, W, 28'h10, 28'h20, 1, 1, 0, 2'b10, 1, 1, 28'h20, 2'b00, 0));
      for (int i = 0; i < 5; i++)
         tv.push_back(mk(2'b11, R, W, 28'h100, 28'h200, 0, 1, 0, 2'b00, 1, 0, 28'h100, 2'b00, 0));
      tv.push_back(mk(2'b11, R, W, 28'h100, 28'h200, 1, 1, 0, 2'b01, 1, 0, 28'h100, 2'b00, 0));
      tv.push_back(mk(2'b10, R, W, 28'h100, 28'h200, 1, 1, 0, 2'b10, 1, 1, 28'h200, 2'b00, 0));
      tv.push_back(mk(2'b00, W, W, 28'h0, 28'h0, 1, 1, 1, 2'b00, 0, 0, 28'h0, 2'b01, 0));
      tv.push_back(mk(2'b10, W, R, 28'h0, 28'hA, 1, 1, 0, 2'b10, 1, 0, 28'hA, 2'b00, 0));
      tv.push_back(mk(2'b01, R, W, 28'hB, 28'h0, 1, 1, 0, 2'b01, 1, 0, 28'hB, 2'b00, 0));
      tv.push_back(mk(2'b10, W, R, 28'h0, 28'hC, 1, 1, 0, 2'b10, 1, 0, 28'hC, 2'b00, 0));
      tv.push_back(mk(2'b00, W, W, 28'h0, 28'h0, 1, 1, 1, 2'b00, 0, 0, 28'h0, 2'b10, 0));
      tv.push_back(mk(2'b00, W, W, 28'h0, 28'h0, 1, 1, 1, 2'b00, 0, 0, 28'h0, 2'b01, 0));
      tv.push_back(mk(2'b00, W, W, 28'h0, 28'h0, 1, 1, 1, 2'b00, 0, 0, 28'h0, 2'b10, 0));
      for (int i = 0; i < 4; i++)
         tv.push_back(mk(2'b01, R, W, 28'h300 + 28'(i), 28'h0, 1, 1, 0, 2'b01, 1, 0,
                         28'h300 + 28'(i), 2'b00, 0));
      tv.push_back(mk(2'b01, R, W, 28'h304, 28'h0, 1, 1, 0, 2'b00, 0, 0, 28'h0, 2'b00, 0));
      tv.push_back(mk(2'b10, R, W, 28'h304, 28'h500, 1, 1, 0, 2'b00, 0, 0, 28'h0, 2'b00, 0));
      tv.push_back(mk(2'b01, R, W, 28'h304, 28'h0, 1, 1, 1, 2'b01, 1, 0, 28'h304, 2'b01, 0));
      for (int i = 0; i < 4; i++)
         tv.push_back(mk(2'b00, W, W, 28'h0, 28'h0, 1, 1, 1, 2'b00, 0, 0, 28'h0, 2'b01, 0));
      tv.push_back(mk(2'b01, W, W, 28'h400, 28'h0, 1, 0, 0, 2'b00, 1, 1, 28'h400, 2'b00, 0));
      tv.push_back(mk(2'b01, W, W, 28'h400, 28'h0, 1, 1, 0, 2'b01, 1, 1, 28'h400, 2'b00, 0));
      tv.push_back(mk(2'b01, X, W, 28'h410, 28'h0, 1, 0, 0, 2'b01, 1, 0, 28'h410, 2'b00, 0));
      tv.push_back(mk(2'b00, W, W, 28'h0, 28'h0, 1, 1, 1, 2'b00, 0, 0, 28'h0, 2'b00, 0));
      tv.push_back(mk(2'b00, W, W, 28'h0, 28'h0, 1, 1, 0, 2'b00, 0, 0, 28'h0, 2'b00, 1));
      tv.push_back(mk(2'b00, W, W, 28'h0, 28'h0, 1, 1, 0, 2'b00, 0, 0, 28'h0, 2'b00, 1));

      foreach (tv[i]) begin
         @(negedge clk);
         ch_en = tv[i].en; c0 = tv[i].c0; c1 = tv[i].c1; a0 = tv[i].a0; a1 = tv[i].a1;
         app_rdy = tv[i].rdy; app_wdf_rdy = tv[i].wrdy; app_rd_data_valid = tv[i].rdv;
         app_rd_data = 32'hC0DE_0000 + 32'(i);
         #1;
         chk($sformatf("v%0d ch_rdy", i), 64'(rr_ch_rdy), 64'(tv[i].x_rdy));
         chk($sformatf("v%0d app_en", i), 64'(rr_en), 64'(tv[i].x_en));
         chk($sformatf("v%0d wren", i), 64'(rr_wren), 64'(tv[i].x_wren));
         chk($sformatf("v%0d wdf_end", i), 64'(rr_wend), 64'(tv[i].x_wren));
         chk($sformatf("v%0d rd_valid", i), 64'(rr_rd_valid), 64'(tv[i].x_rdv));
         chk($sformatf("v%0d tag_err", i), 64'(rr_err), 64'(tv[i].x_err));
         if (tv[i].x_en) begin
            chk($sformatf("v%0d addr", i), 64'(rr_addr), 64'(tv[i].x_addr));
            chk($sformatf("v%0d cmd", i), 64'(rr_cmd),
                64'(tv[i].x_addr == tv[i].a0 && tv[i].x_rdy != 2'b10 ? tv[i].c0 : tv[i].c1));
         end
         if (tv[i].x_wren) begin
            chk($sformatf("v%0d wdata", i), 64'(rr_wdata), 64'({4'hD, tv[i].x_addr}));
            chk($sformatf("v%0d wmask", i), 64'(rr_mask), 64'(tv[i].x_addr[3:0]));
         end
         if (tv[i].rdv)
            chk($sformatf("v%0d rd_data", i), 64'(rr_rd_data), 64'(32'hC0DE_0000 + 32'(i)));
      end

      // asynchronous reset clears the sticky error and silences a live request at once
      @(negedge clk);
      idle_inputs();
      ch_en = 2'b01; c0 = R; a0 = 28'h600; app_rdy = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("async tag_err", 64'(rr_err), 64'h0);
      chk("async app_en", 64'(rr_en), 64'h0);
      chk("async ch_rdy", 64'(rr_ch_rdy), 64'h0);
      ch_en = '0;
      @(negedge clk);
      rst_n = 1'b1;

      // reset between a read accept and its return discards the tag
      @(negedge clk);
      ch_en = 2'b01; c0 = R; a0 = 28'h600; app_rdy = 1'b1;
      #1 chk("midrst accept", 64'(rr_ch_rdy), 64'h1);
      @(negedge clk);
      idle_inputs();
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      @(negedge clk);
      app_rd_data_valid = 1'b1;
      #1 chk("midrst rd_valid", 64'(rr_rd_valid), 64'h0);
      @(negedge clk);
      app_rd_data_valid = 1'b0;
      #1 chk("midrst tag_err", 64'(rr_err), 64'h1);

      // fixed priority: ch0 drains its three writes before ch1 is served
      @(negedge clk);
      idle_inputs();
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         ch_en = (i < 3) ? 2'b11 : 2'b10;
         c0 = W; c1 = W; a0 = 28'h700 + 28'(i); a1 = 28'h800 + 28'(i);
         app_rdy = 1'b1; app_wdf_rdy = 1'b1;
         #1;
         chk($sformatf("prio%0d ch_rdy", i), 64'(pr_ch_rdy), (i < 3) ? 64'h1 : 64'h2);
         chk($sformatf("prio%0d addr", i), 64'(pr_addr),
             (i < 3) ? 64'(28'h700 + 28'(i)) : 64'(28'h800 + 28'(i)));
      end
      @(negedge clk);
      idle_inputs();
`ifdef DDR_ARB_PERF_EN
      #1;
      chk("perf_cnt ch0", 64'(pr_pcnt[31:0]), 64'd3);
      chk("perf_cnt ch1", 64'(pr_pcnt[63:32]), 64'd3);
      chk("perf_stall ch0", 64'(pr_pstall[31:0]), 64'd0);
      chk("perf_stall ch1", 64'(pr_pstall[63:32]), 64'd3);
      perf_clr = 1'b1;
      @(negedge clk);
      perf_clr = 1'b0;
      chk("perf_clr cnt", 64'(pr_pcnt), 64'd0);
      chk("perf_clr stall", 64'(pr_pstall), 64'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
